// File: rtl/booth_pkg.sv
// Shared constants and state encoding for the radix-2 Booth multiplier controller.
package booth_pkg;

  localparam int unsigned BOOTH_WIDTH = 6;
  localparam int unsigned BOOTH_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDX   = 3'd1,
    LDY   = 3'd2,
    EVAL  = 3'd3,
    SHIFT = 3'd4,
    OUTH  = 3'd5,
    OUTL  = 3'd6
  } state_t;

  // {Y0,Y-1} recoding: 01 adds X into A, 10 subtracts it, 00/11 leave A alone.
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration down-counter: loaded with WIDTH, decremented once per shift, flags the final pass.
module booth_iter_counter
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH,
  parameter int unsigned CNT_W = BOOTH_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WIDTH);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The shift happening while cnt is 1 is the last iteration.
  always_comb begin
    last = (cnt == CNT_W'(1));
  end

endmodule

// File: rtl/booth_controller.sv
// Control FSM sequencing the radix-2 Booth multiplier datapath: load X, load Y,
// WIDTH evaluate/shift iterations, then product high half and low half onto the bus.
module booth_controller
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH,
  parameter int unsigned CNT_W = BOOTH_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Y0YminusOne,
  output logic       ready,
  output logic       ldX,
  output logic       ldY,
  output logic       initA,
  output logic       initYminusOne,
  output logic       ldA,
  output logic       aBarS,
  output logic       shRA,
  output logic       shRY,
  output logic       ldYminusOne,
  output logic       selL,
  output logic       selR,
  output logic       done
);

  state_t state;
  state_t state_nxt;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_last;

  booth_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .clk  (clk),
    .rst_n(rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .last (cnt_last)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore output decode; only ldA/aBarS look at the datapath in EVAL.
  always_comb begin
    state_nxt     = state;
    ready         = 1'b0;
    ldX           = 1'b0;
    ldY           = 1'b0;
    initA         = 1'b0;
    initYminusOne = 1'b0;
    ldA           = 1'b0;
    aBarS         = 1'b0;
    shRA          = 1'b0;
    shRY          = 1'b0;
    ldYminusOne   = 1'b0;
    selL          = 1'b0;
    selR          = 1'b0;
    done          = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = LDX;
        end
      end
      LDX: begin
        ldX       = 1'b1;
        state_nxt = LDY;
      end
      LDY: begin
        ldY           = 1'b1;
        initA         = 1'b1;
        initYminusOne = 1'b1;
        cnt_load      = 1'b1;
        state_nxt     = EVAL;
      end
      EVAL: begin
        // Always spent, even when no add/sub is needed, to keep latency fixed.
        if (Y0YminusOne == ADD) begin
          ldA = 1'b1;
        end else if (Y0YminusOne == SUB) begin
          ldA   = 1'b1;
          aBarS = 1'b1;
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shRA        = 1'b1;
        shRY        = 1'b1;
        ldYminusOne = 1'b1;
        cnt_dec     = 1'b1;
        state_nxt   = cnt_last ? OUTH : EVAL;
      end
      OUTH: begin
        selL      = 1'b1;
        state_nxt = OUTL;
      end
      OUTL: begin
        selR      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Bench: Booth controller driving a behavioural datapath; control timing and the
// product on the output bus are checked against a cycle-indexed reference model.
module tb_booth_controller;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   Y0YminusOne;
  logic         ready, ldX, ldY, initA, initYminusOne, ldA, aBarS;
  logic         shRA, shRY, ldYminusOne, selL, selR, done;

  logic [W-1:0] in_bus = '0;
  logic [W-1:0] xr;
  logic [W-1:0] yr;
  logic [W:0]   ar;
  logic         ym1;
  logic [W-1:0] out_bus;
  logic [12:0]  ctl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Y0YminusOne  (Y0YminusOne),
    .ready        (ready),
    .ldX          (ldX),
    .ldY          (ldY),
    .initA        (initA),
    .initYminusOne(initYminusOne),
    .ldA          (ldA),
    .aBarS        (aBarS),
    .shRA         (shRA),
    .shRY         (shRY),
    .ldYminusOne  (ldYminusOne),
    .selL         (selL),
    .selR         (selR),
    .done         (done)
  );

  // Datapath model; A carries a guard bit so X = -32 cannot overflow the accumulator.
  always @(posedge clk) begin
    if (ldX) xr <= in_bus;
    if (ldY) yr <= in_bus;
    if (initA) ar <= '0;
    if (initYminusOne) ym1 <= 1'b0;
    if (ldA) ar <= aBarS ? (ar - {xr[W-1], xr}) : (ar + {xr[W-1], xr});
    if (shRA) ar <= {ar[W], ar[W:1]};
    if (shRY) yr <= {ar[0], yr[W-1:1]};
    if (ldYminusOne) ym1 <= yr[0];
  end

  assign Y0YminusOne = {yr[0], ym1};
  assign out_bus = selL ? ar[W-1:0] : (selR ? yr : '0);
  assign ctl = {ready, ldX, ldY, initA, initYminusOne, ldA, aBarS,
                shRA, shRY, ldYminusOne, selL, selR, done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control word k cycles after the start edge (k=0: idle); y is the multiplier.
  function automatic logic [12:0] exp_ctl(input int k, input logic [W-1:0] y);
    logic [W:0] ye;
    logic [1:0] pair;
    logic rdy, lx, ly, ia, iy, la, ab, sa, sy, lym, sl, sr, dn;
    int i;
    ye = {y, 1'b0};
    rdy = 0; lx = 0; ly = 0; ia = 0; iy = 0; la = 0; ab = 0;
    sa = 0; sy = 0; lym = 0; sl = 0; sr = 0; dn = 0;
    if (k == 0) rdy = 1'b1;
    if (k == 1) lx = 1'b1;
    if (k == 2) begin ly = 1'b1; ia = 1'b1; iy = 1'b1; end
    if (k >= 3 && k <= 3 + 2 * (W - 1) && (k % 2) == 1) begin
      i = (k - 3) / 2;
      pair = {ye[i+1], ye[i]};
      la = (pair == 2'b01) || (pair == 2'b10);
      ab = (pair == 2'b10);
    end
    if (k >= 4 && k <= 2 + 2 * W && (k % 2) == 0) begin
      sa = 1'b1; sy = 1'b1; lym = 1'b1;
    end
    if (k == 3 + 2 * W) sl = 1'b1;
    if (k == 4 + 2 * W) begin sr = 1'b1; dn = 1'b1; end
    return {rdy, lx, ly, ia, iy, la, ab, sa, sy, lym, sl, sr, dn};
  endfunction

  // One multiply from an idle cycle; keep holds start high, abort_k>0 resets at that cycle.
  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit keep, input int abort_k);
    int px, py;
    logic [2*W-1:0] p;
    px = int'($signed(x));
    py = int'($signed(y));
    p  = (2*W)'(px * py);
    @(negedge clk);
    chk("idle_ready", 32'(ctl), 32'(exp_ctl(0, y)));
    in_bus = x;
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
    for (int k = 1; k <= 4 + 2 * W; k++) begin
      @(negedge clk);
      chk($sformatf("ctl_k%0d", k), 32'(ctl), 32'(exp_ctl(k, y)));
      if (k == 2) in_bus = y;
      if (k == abort_k) begin
        start = 1'b0;
        #1 rst = 1'b0;
        #1 chk("abort_async", 32'(ctl), 32'(exp_ctl(0, y)));
        @(negedge clk);
        chk("abort_held", 32'(ctl), 32'(exp_ctl(0, y)));
        rst = 1'b1;
        return;
      end
      if (k == 3 + 2 * W) chk($sformatf("hi %0d*%0d", px, py), 32'(out_bus), 32'(p[2*W-1:W]));
      if (k == 4 + 2 * W) chk($sformatf("lo %0d*%0d", px, py), 32'(out_bus), 32'(p[W-1:0]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rx, ry;
    bit keep;
    #3;
    chk("reset_ctl", 32'(ctl), 32'(exp_ctl(0, '0)));
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle_c%0d", c), 32'(ctl), 32'(exp_ctl(0, '0)));
    end

    do_mult(6'd3, 6'd5, 1'b0, 0);
    do_mult(6'h3f, 6'b010101, 1'b0, 0);
    do_mult(6'd1, 6'b100000, 1'b0, 0);
    do_mult(6'b100000, 6'b100000, 1'b0, 0);
    do_mult(6'd2, 6'd7, 1'b1, 0);
    do_mult(6'b111101, 6'd4, 1'b0, 0);
    do_mult(6'd9, 6'd11, 1'b0, 8);
    do_mult(6'd6, 6'd6, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      keep = (n != 23) && ($urandom_range(0, 1) == 1);
      do_mult(rx, ry, keep, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
